gpc1325_seq_acc: RTL and testbench
==================================

Name: gpc1325_seq_acc

Overview:
- Time-multiplexed weighted-popcount engine built around one shared gpc1325_5 instance.
- Accepts a batch of up to N_CHUNKS 11-bit GPC input chunks via valid/ready.
- Streams one chunk per cycle through the GPC and accumulates the 5-bit GPC results into a running sum.
- Returns the total via valid/ready; used where a full compressor tree is too large and throughput can be traded for area.

Parameters:
- N_CHUNKS, 8, maximum chunks per batch (>=1).
- CNT_W, $clog2(N_CHUNKS+1), width of chunk-count fields.
- ACC_W, $clog2(29*N_CHUNKS+1), accumulator/result width (8 at default).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  batch offered.
- in_ready  out  1  block can accept a batch.
- in_data  in  11*N_CHUNKS  chunk k at bits [11k+10:11k].
- in_count  in  CNT_W  number of valid chunks (0..N_CHUNKS), starting from chunk 0.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_sum  out  ACC_W  weighted sum of all valid chunks.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Chunk layout, fixed:
  - bits[4:0] -> src0 (weight 1)
  - bits[6:5] -> src1 (weight 2)
  - bits[9:7] -> src2 (weight 4)
  - bit[10] -> src3 (weight 8)
  - Max per chunk is 29, so the 5-bit GPC dst cannot overflow.
- Reset (rst_n==0 at clk edge):
  - state=IDLE; acc=0; idx=0; cnt=0; batch register=0.
  - Outputs: in_ready=1, out_valid=0, out_sum=0, busy=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE:
    - in_ready=1.
    - On in_valid: latch in_data and in_count, clear acc and idx.
    - If in_count==0, go to DONE; if in_count>N_CHUNKS, clamp to N_CHUNKS and go to RUN; otherwise go to RUN.
  - RUN:
    - in_ready=0.
    - GPC inputs are the latched chunk[idx] (combinational path into the GPC).
    - acc <= acc + zero-extended dst; idx <= idx+1.
    - When idx==cnt-1, go to DONE on the same edge that adds the last chunk.
  - DONE:
    - out_valid=1, out_sum=acc; both held stable while out_ready==0.
    - On out_ready: go to IDLE and drop out_valid next cycle.
- Latency:
  - Accept edge at cycle 0; out_valid rises in cycle cnt+1.
  - cnt==0 gives out_valid in cycle 1.
  - No back-to-back overlap: the next batch is accepted at the earliest one cycle after the out handshake (IDLE cycle).
- Arithmetic: acc is ACC_W bits, unsigned. No wrap is possible by parameter construction; no saturation logic.
- Input changes: in_data and in_count changes outside the accept cycle are ignored, because the batch is latched.
- Mid-operation reset: in RUN or DONE, returns to IDLE next cycle; out_valid=0; the partial sum is discarded.
- No combinational path from out_ready to in_ready.

Decomposition:
- Package gpc_pkg:
  - Chunk-field constants: SRC0_LSB=0/W=5, SRC1_LSB=5/W=2, SRC2_LSB=7/W=3, SRC3_LSB=10/W=1, CHUNK_W=11, GPC_OUT_W=5.
  - Chunk max value 29.
  - Enum state_t {IDLE, RUN, DONE}.
- Sub-module: the existing gpc1325_5 (src0, src1, src2, src3, dst), instantiated once.
- The FSM, index counter and accumulator stay in the top module.

Test Plan:
- Single chunk 0x6C2, count=1 -> out_sum=0x13 (19), out_valid in cycle 2 after accept.
- Chunks [0x6C2, 0x752], count=2 -> out_sum=0x27 (39), out_valid in cycle 3; in_ready=0 from cycle 1 until IDLE.
- All 8 chunks 0x7FF, count=8 -> out_sum=0xE8 (232), no overflow; count=0 -> out_sum=0 with out_valid in cycle 1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE with in_valid=1 -> out_sum stable, in_ready=0, no second accept; release -> handshake, IDLE, next batch accepted one cycle later.
- rst_n=0 during RUN of a count=8 batch -> next cycle busy=0, in_ready=1, out_valid=0; new batch 0x6C2 then returns 0x13.
- Random: 200 batches, random count 0..8 and random chunk bits -> out_sum equals the reference weighted sum.

Source files
------------

// File: rtl/gpc_pkg.sv
// gpc_pkg: chunk field layout, limits and FSM state type for the sequential GPC accumulator.
package gpc_pkg;
    localparam int SRC0_LSB  = 0;
    localparam int SRC0_W    = 5;
    localparam int SRC1_LSB  = 5;
    localparam int SRC1_W    = 2;
    localparam int SRC2_LSB  = 7;
    localparam int SRC2_W    = 3;
    localparam int SRC3_LSB  = 10;
    localparam int SRC3_W    = 1;
    localparam int CHUNK_W   = 11;
    localparam int GPC_OUT_W = 5;
    localparam int CHUNK_MAX = 29;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/gpc1325_5.sv
// gpc1325_5: (1,3,2,5;5) generalized parallel counter, weighted popcount of four bit columns.
module gpc1325_5 (
    input  logic [4:0] src0,
    input  logic [1:0] src1,
    input  logic [2:0] src2,
    input  logic       src3,
    output logic [4:0] dst
);
    always_comb begin
        dst = {1'b0, src3, 3'b000};
        for (int k = 0; k < 5; k++) dst = dst + {4'b0000, src0[k]};
        for (int k = 0; k < 2; k++) dst = dst + {3'b000, src1[k], 1'b0};
        for (int k = 0; k < 3; k++) dst = dst + {2'b00, src2[k], 2'b00};
    end
endmodule

// File: rtl/gpc1325_seq_acc.sv
// gpc1325_seq_acc: streams a latched batch of chunks through one shared GPC and accumulates the weighted sum.
module gpc1325_seq_acc
    import gpc_pkg::*;
#(
    parameter int N_CHUNKS = 8,
    parameter int CNT_W    = $clog2(N_CHUNKS + 1),
    parameter int ACC_W    = $clog2(CHUNK_MAX * N_CHUNKS + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CHUNK_W*N_CHUNKS-1:0] in_data,
    input  logic [CNT_W-1:0]            in_count,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ACC_W-1:0]            out_sum,
    output logic                        busy
);
    state_t                      r_state, w_next;
    logic [CHUNK_W*N_CHUNKS-1:0] r_batch;
    logic [CNT_W-1:0]            r_cnt, r_idx, w_cnt;
    logic [ACC_W-1:0]            r_acc;
    logic [CHUNK_W-1:0]          w_chunks [2**CNT_W];
    logic [CHUNK_W-1:0]          w_chunk;
    logic [GPC_OUT_W-1:0]        w_dst;
    logic                        w_last, w_accept;

    // Array padded to a power of two so any idx value selects a defined entry.
    for (genvar k = 0; k < 2**CNT_W; k++) begin : g_chunk
        if (k < N_CHUNKS) begin : g_real
            assign w_chunks[k] = r_batch[k*CHUNK_W +: CHUNK_W];
        end else begin : g_pad
            assign w_chunks[k] = '0;
        end
    end

    assign w_chunk  = w_chunks[r_idx];
    assign w_cnt    = (in_count > CNT_W'(N_CHUNKS)) ? CNT_W'(N_CHUNKS) : in_count;
    assign w_last   = (r_idx == r_cnt - CNT_W'(1));
    assign w_accept = (r_state == IDLE) && in_valid;

    gpc1325_5 u_gpc (
        .src0(w_chunk[SRC0_LSB +: SRC0_W]),
        .src1(w_chunk[SRC1_LSB +: SRC1_W]),
        .src2(w_chunk[SRC2_LSB +: SRC2_W]),
        .src3(w_chunk[SRC3_LSB]),
        .dst (w_dst)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = in_valid ? ((w_cnt == '0) ? DONE : RUN) : IDLE;
            RUN:     w_next = w_last ? DONE : RUN;
            DONE:    w_next = out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_batch <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_batch <= in_data;
                r_cnt   <= w_cnt;
                r_idx   <= '0;
                r_acc   <= '0;
            end else if (r_state == RUN) begin
                r_idx <= r_idx + CNT_W'(1);
                r_acc <= r_acc + ACC_W'(w_dst);
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign out_sum   = out_valid ? r_acc : '0;
endmodule

// File: tb/tb_gpc1325_seq_acc.sv
// tb_gpc1325_seq_acc: scoreboard bench for the sequential GPC accumulator.
module tb_gpc1325_seq_acc;
    localparam int N  = 8;
    localparam int CW = 4;
    localparam int AW = 8;
    localparam int DW = 11 * N;

    logic          clk = 1'b0;
    logic          rst_n, in_valid, in_ready, out_valid, out_ready, busy;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_count;
    logic [AW-1:0] out_sum;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            exp_q[$];

    always #5 clk = ~clk;

    gpc1325_seq_acc dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_count(in_count), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .busy(busy)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_sum(input logic [DW-1:0] d, input int c);
        int          s;
        int          lim;
        logic [10:0] ch;
        s   = 0;
        lim = (c > N) ? N : c;
        for (int i = 0; i < lim; i++) begin
            ch = d[i*11 +: 11];
            s += $countones(ch[4:0]) + 2 * $countones(ch[6:5]) + 4 * $countones(ch[9:7]) + 8 * int'(ch[10]);
        end
        return s;
    endfunction

    task automatic accept(input logic [DW-1:0] d, input int c, input int exp);
        in_data  = d;
        in_count = CW'(c);
        in_valid = 1'b1;
        chk("acc_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = DW'({$urandom, $urandom, $urandom});
        in_count = CW'($urandom);
        exp_q.push_back(exp);
    endtask

    task automatic collect(input int lat, input string tag);
        int cyc = 0;
        while (!out_valid && cyc < 50) begin
            chk({tag, "_busy"}, int'(busy), 1);
            chk({tag, "_inrdy"}, int'(in_ready), 0);
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_lat"}, cyc, lat);
        chk({tag, "_ovalid"}, int'(out_valid), 1);
        if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 1, 0);
        else chk({tag, "_sum"}, int'(out_sum), exp_q.pop_front());
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_drop"}, int'(out_valid), 0);
        chk({tag, "_idle"}, int'(in_ready), 1);
    endtask

    initial begin
        logic [DW-1:0] d;
        int            c;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_count = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_inrdy", int'(in_ready), 1);
        chk("rst_ovalid", int'(out_valid), 0);
        chk("rst_sum", int'(out_sum), 0);
        chk("rst_busy", int'(busy), 0);

        accept(DW'(11'h6C2), 1, 19);
        collect(1, "one");
        accept(DW'({11'h752, 11'h6C2}), 2, 39);
        collect(2, "two");
        accept({N{11'h7FF}}, 8, 232);
        collect(8, "full");
        accept({N{11'h7FF}}, 0, 0);
        collect(0, "zero");
        accept({N{11'h7FF}}, 13, 232);
        collect(8, "clamp");

        // Backpressure: result held while a new batch is already offered.
        accept(DW'(11'h6C2), 1, 19);
        @(posedge clk); #1;
        chk("bp_ovalid", int'(out_valid), 1);
        in_valid = 1'b1; in_data = DW'(11'h752); in_count = CW'(1);
        repeat (3) begin
            chk("bp_sum", int'(out_sum), 19);
            chk("bp_inrdy", int'(in_ready), 0);
            chk("bp_hold", int'(out_valid), 1);
            @(posedge clk); #1;
        end
        chk("bp_sum_final", int'(out_sum), exp_q.pop_front());
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_drop", int'(out_valid), 0);
        chk("bp_idle_rdy", int'(in_ready), 1);
        chk("bp_idle_busy", int'(busy), 0);
        exp_q.push_back(20);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_reaccept", int'(busy), 1);
        collect(1, "bp2");

        // Reset in the middle of a batch discards it.
        in_data = {N{11'h7FF}}; in_count = CW'(8); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_inrdy", int'(in_ready), 1);
        chk("mrst_ovalid", int'(out_valid), 0);
        rst_n = 1'b1;
        accept(DW'(11'h6C2), 1, 19);
        collect(1, "post_rst");

        for (int i = 0; i < 200; i++) begin
            d = DW'({$urandom, $urandom, $urandom});
            c = $urandom_range(0, 8);
            accept(d, c, ref_sum(d, c));
            collect(c, "rnd");
        end

        chk("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
